yuv422_stream_feeder: RTL and testbench

- Upstream feeder for the colour-space converter in YUV-to-RGB mode.
- Accepts packed 4:2:2 pixel pairs {U,Y0,V,Y1} as 32-bit words over a valid/ready interface and buffers them in a small word FIFO.
- Serializes each word into the converter's byte protocol: yuv_in/in_en, U then Y0 then V then Y1.
- Pauses on the converter's busy after the V and Y1 bytes. Tracks delivered pixel pairs and flags protocol timeouts.

---
 rtl/yuv422_stream_feeder_pkg.sv | 26 ++
 rtl/yuv422_stream_feeder_fifo.sv | 49 ++++
 rtl/yuv422_stream_feeder.sv | 163 ++++++++++++++++
 tb/tb_yuv422_stream_feeder.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/yuv422_stream_feeder_pkg.sv
// rtl/yuv422_stream_feeder_pkg.sv - shared constants and FSM encoding for the YUV 4:2:2 feeder
package yuv422_stream_feeder_pkg;

    localparam int BW     = 8;
    localparam int U_LSB  = 24;
    localparam int Y0_LSB = 16;
    localparam int V_LSB  = 8;
    localparam int Y1_LSB = 0;

    localparam logic OP_YUV2RGB = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_B_U,
        ST_B_Y0,
        ST_B_V,
        ST_WAIT_HI,
        ST_WAIT_LO,
        ST_B_Y1
    } state_t;

    function automatic logic [BW-1:0] byte_lane(input logic [31:0] word, input int lsb);
        return word[lsb +: BW];
    endfunction

endpackage

// File: rtl/yuv422_stream_feeder_fifo.sv
// rtl/yuv422_stream_feeder_fifo.sv - DEPTH x WIDTH synchronous word FIFO with flush
module yuv_word_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign do_push  = push && !full && !flush;
    assign do_pop   = pop && !empty && !flush;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/yuv422_stream_feeder.sv
// rtl/yuv422_stream_feeder.sv - buffers packed 4:2:2 words and serializes them into converter bytes
module yuv422_stream_feeder
    import yuv422_stream_feeder_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int BUSY_TMO = 4,
    parameter int CNT_BW   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    input  logic [31:0]       s_data,
    output logic              s_ready,
    output logic              op_mode,
    output logic              in_en,
    output logic [BW-1:0]     yuv_in,
    input  logic              busy,
    output logic [CNT_BW-1:0] pair_cnt,
    output logic              tmo_err,
    input  logic              clr
);

    localparam int TW = $clog2(BUSY_TMO + 1);

    state_t            state, state_n;
    logic              ret_y1, ret_y1_n;
    logic [31:0]       hold, hold_n;
    logic [TW-1:0]     tmr, tmr_n;
    logic              in_en_n;
    logic [BW-1:0]     yuv_in_n;
    logic [CNT_BW-1:0] pair_cnt_n;
    logic              tmo_err_n;
    logic              rdy_q;

    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [31:0]       fifo_data;
    logic              fifo_push;

    assign op_mode   = OP_YUV2RGB;
    // rdy_q holds s_ready low while reset is asserted.
    assign s_ready   = rdy_q && !fifo_full;
    assign fifo_push = s_valid && s_ready && !clr;

    yuv_word_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (clr),
        .push      (fifo_push),
        .push_data (s_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            ret_y1   <= 1'b0;
            hold     <= '0;
            tmr      <= '0;
            in_en    <= 1'b0;
            yuv_in   <= '0;
            pair_cnt <= '0;
            tmo_err  <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state    <= state_n;
            ret_y1   <= ret_y1_n;
            hold     <= hold_n;
            tmr      <= tmr_n;
            in_en    <= in_en_n;
            yuv_in   <= yuv_in_n;
            pair_cnt <= pair_cnt_n;
            tmo_err  <= tmo_err_n;
            rdy_q    <= 1'b1;
        end
    end

    // Byte states only strobe when busy is low, so in_en never follows a busy sample.
    always_comb begin
        state_n    = state;
        ret_y1_n   = ret_y1;
        hold_n     = hold;
        tmr_n      = tmr;
        in_en_n    = 1'b0;
        yuv_in_n   = yuv_in;
        pair_cnt_n = pair_cnt;
        tmo_err_n  = tmo_err;
        fifo_pop   = 1'b0;

        if (clr) begin
            state_n    = ST_IDLE;
            ret_y1_n   = 1'b0;
            tmr_n      = '0;
            pair_cnt_n = '0;
            tmo_err_n  = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty && !busy) begin
                        fifo_pop = 1'b1;
                        hold_n   = fifo_data;
                        state_n  = ST_B_U;
                    end
                end
                ST_B_U: begin
                    if (!busy) begin
                        in_en_n  = 1'b1;
                        yuv_in_n = byte_lane(hold, U_LSB);
                        state_n  = ST_B_Y0;
                    end
                end
                ST_B_Y0: begin
                    if (!busy) begin
                        in_en_n  = 1'b1;
                        yuv_in_n = byte_lane(hold, Y0_LSB);
                        state_n  = ST_B_V;
                    end
                end
                ST_B_V: begin
                    if (!busy) begin
                        in_en_n  = 1'b1;
                        yuv_in_n = byte_lane(hold, V_LSB);
                        ret_y1_n = 1'b1;
                        tmr_n    = '0;
                        state_n  = ST_WAIT_HI;
                    end
                end
                ST_WAIT_HI: begin
                    if (busy) begin
                        state_n = ST_WAIT_LO;
                    end else if (tmr == TW'(BUSY_TMO - 1)) begin
                        tmo_err_n = 1'b1;
                        state_n   = ST_WAIT_LO;
                    end else begin
                        tmr_n = tmr + TW'(1);
                    end
                end
                ST_WAIT_LO: begin
                    if (!busy) state_n = ret_y1 ? ST_B_Y1 : ST_IDLE;
                end
                ST_B_Y1: begin
                    if (!busy) begin
                        in_en_n    = 1'b1;
                        yuv_in_n   = byte_lane(hold, Y1_LSB);
                        pair_cnt_n = pair_cnt + CNT_BW'(1);
                        ret_y1_n   = 1'b0;
                        tmr_n      = '0;
                        state_n    = ST_WAIT_HI;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_yuv422_stream_feeder.sv
// tb/tb_yuv422_stream_feeder.sv - directed self-checking bench for yuv422_stream_feeder
module tb_yuv422_stream_feeder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = '0;
    logic        busy = 1'b0;
    logic        clr = 1'b0;

    logic        s_ready, op_mode, in_en, tmo_err;
    logic [7:0]  yuv_in;
    logic [15:0] pair_cnt;
    logic        s_ready_s, op_mode_s, in_en_s, tmo_err_s;
    logic [7:0]  yuv_in_s;
    logic [3:0]  pair_cnt_s;

    int checks = 0;
    int failures = 0;

    logic [7:0] rx [$];
    logic [7:0] exp_q [$];
    int   phase = 0;
    logic pend = 1'b0;
    logic busy_en = 1'b1;
    logic clr_q = 1'b0;
    int   viol = 0;
    logic nr_seen = 1'b0;

    always #5 clk = ~clk;

    yuv422_stream_feeder #(.DEPTH(4), .BUSY_TMO(4), .CNT_BW(16)) dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .op_mode(op_mode), .in_en(in_en), .yuv_in(yuv_in), .busy(busy),
        .pair_cnt(pair_cnt), .tmo_err(tmo_err), .clr(clr)
    );

    yuv422_stream_feeder #(.DEPTH(4), .BUSY_TMO(4), .CNT_BW(4)) dut_small (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready_s),
        .op_mode(op_mode_s), .in_en(in_en_s), .yuv_in(yuv_in_s), .busy(busy),
        .pair_cnt(pair_cnt_s), .tmo_err(tmo_err_s), .clr(clr)
    );

    always @(posedge clk) clr_q <= clr;

    // Converter model: raises busy for one cycle, one cycle after each V and Y1 strobe.
    always @(negedge clk) begin
        logic np;
        np = 1'b0;
        if (!reset || clr_q) begin
            phase = 0;
            pend  = 1'b0;
            busy  = 1'b0;
        end else begin
            if (in_en && busy) viol++;
            if (in_en) begin
                rx.push_back(yuv_in);
                np    = busy_en && (phase == 2 || phase == 3);
                phase = (phase + 1) % 4;
            end
            busy = pend;
            pend = np;
        end
    end

    task automatic chk(input logic [31:0] obs, input logic [31:0] expv, input string tag);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_word(input logic [31:0] d);
        int t;
        t = 0;
        s_data  = d;
        s_valid = 1'b1;
        while (!s_ready && t < 300) begin
            nr_seen = 1'b1;
            @(negedge clk);
            t++;
        end
        if (t >= 300) chk(32'(t), 32'd0, "push_timeout");
        @(negedge clk);
        s_valid = 1'b0;
        exp_q.push_back(d[31:24]);
        exp_q.push_back(d[23:16]);
        exp_q.push_back(d[15:8]);
        exp_q.push_back(d[7:0]);
    endtask

    task automatic wait_rx(input int n, input string tag);
        int t;
        t = 0;
        while (rx.size() < n && t < 3000) begin
            @(negedge clk);
            t++;
        end
        repeat (16) @(negedge clk);
        chk(32'(rx.size()), 32'(n), tag);
    endtask

    task automatic cmp_bytes(input int base, input int ebase, input int n, input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            if (base + i >= rx.size() || ebase + i >= exp_q.size()) bad++;
            else if (rx[base+i] !== exp_q[ebase+i]) bad++;
        end
        chk(32'(bad), 32'd0, tag);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int base, ebase, t;

        #2;
        chk(32'(s_ready), 32'd0, "rst_s_ready");
        chk(32'(in_en), 32'd0, "rst_in_en");
        chk(32'(yuv_in), 32'd0, "rst_yuv_in");
        chk(32'(pair_cnt), 32'd0, "rst_pair_cnt");
        chk(32'(tmo_err), 32'd0, "rst_tmo_err");
        chk(32'(op_mode), 32'd0, "op_mode");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk(32'(s_ready), 32'd1, "s_ready_after_rst");

        // 1: single word and latency
        base = rx.size(); ebase = exp_q.size();
        push_word(32'h8010_80EB);
        chk(32'(in_en), 32'd0, "lat_cycle1");
        @(negedge clk);
        chk(32'(in_en), 32'd0, "lat_cycle2");
        @(negedge clk);
        chk(32'({in_en, yuv_in}), 32'h180, "lat_u_byte");
        wait_rx(base + 4, "t1_count");
        cmp_bytes(base, ebase, 4, "t1_bytes");
        chk(32'(pair_cnt), 32'd1, "t1_pair_cnt");
        chk(32'(viol), 32'd0, "t1_busy_rule");

        // 2: burst of 6 with back-pressure
        base = rx.size(); ebase = exp_q.size();
        nr_seen = 1'b0;
        for (int i = 0; i < 6; i++) push_word(32'h0102_0304 + 32'(i) * 32'h1010_1010);
        chk(32'(nr_seen), 32'd1, "t2_s_ready_drop");
        wait_rx(base + 24, "t2_count");
        cmp_bytes(base, ebase, 24, "t2_bytes");
        chk(32'(pair_cnt), 32'd7, "t2_pair_cnt");
        chk(32'(viol), 32'd0, "t2_busy_rule");

        // 3: busy never rises
        pulse_clr();
        chk(32'(pair_cnt), 32'd0, "t3_clr_cnt");
        busy_en = 1'b0;
        base = rx.size(); ebase = exp_q.size();
        push_word(32'h5566_7788);
        t = 0;
        while (!(in_en && yuv_in == 8'h77) && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk(32'(tmo_err), 32'd0, "t3_tmo_before");
        t = 0;
        while (!tmo_err && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk(32'(t), 32'd4, "t3_tmo_cycles");
        wait_rx(base + 4, "t3_count");
        cmp_bytes(base, ebase, 4, "t3_bytes");
        chk(32'(tmo_err), 32'd1, "t3_tmo_sticky");
        pulse_clr();
        chk(32'(tmo_err), 32'd0, "t3_tmo_clr");
        busy_en = 1'b1;

        // 4: clr right after Y0
        base = rx.size();
        push_word(32'h1122_3344);
        push_word(32'hAABB_CCDD);
        push_word(32'hA1B2_C3D4);
        t = 0;
        while (!(in_en && yuv_in == 8'h22) && t < 50) begin
            @(negedge clk);
            t++;
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk(32'(in_en), 32'd0, "t4_in_en_after_clr");
        repeat (20) @(negedge clk);
        chk(32'(rx.size()), 32'(base + 2), "t4_no_more_bytes");
        chk(32'(pair_cnt), 32'd0, "t4_pair_cnt");
        chk(32'(s_ready), 32'd1, "t4_fifo_empty");

        // 5: asynchronous reset mid-burst
        push_word(32'h0F1E_2D3C);
        push_word(32'h4B5A_6978);
        t = 0;
        while (!(in_en && yuv_in == 8'h1E) && t < 50) begin
            @(negedge clk);
            t++;
        end
        #2 reset = 1'b0;
        #1;
        chk(32'(in_en), 32'd0, "t5_in_en_async");
        chk(32'(s_ready), 32'd0, "t5_s_ready_rst");
        chk(32'(pair_cnt), 32'd0, "t5_pair_cnt");
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        chk(32'(s_ready), 32'd1, "t5_s_ready_release");
        repeat (10) @(negedge clk);
        base = rx.size(); ebase = exp_q.size();
        push_word(32'hA0B0_C0D0);
        wait_rx(base + 4, "t5_count");
        cmp_bytes(base, ebase, 4, "t5_bytes");
        chk(32'(pair_cnt), 32'd1, "t5_pair_cnt_after");

        // 6: counter wrap on the 4-bit instance
        pulse_clr();
        base = rx.size();
        for (int i = 0; i < 17; i++) push_word(32'h2000_0000 + 32'(i));
        wait_rx(base + 68, "t6_count");
        chk(32'(pair_cnt_s), 32'd1, "t6_wrap");
        chk(32'(pair_cnt), 32'd17, "t6_wide_cnt");
        chk(32'(viol), 32'd0, "t6_busy_rule");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
